// File: rtl/jk_register_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jkreg_pkg
//  Description : Shared mode and direction encodings for jk_register_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package jkreg_pkg;

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_LEFT = 1'b1;

endpackage : jkreg_pkg
`default_nettype wire

// File: rtl/jk_register_bank_jk_next_bit.sv
`default_nettype none
// ============================================================================
//  Module      : jk_next_bit
//  Description : Combinational next state of a single JK bit.
//                {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_next_bit (
    input  logic i_q,
    input  logic i_j,
    input  logic i_k,
    output logic o_q_next
);

    // Classic JK characteristic table
    always_comb begin
        o_q_next = i_q;
        unique case ({i_j, i_k})
            2'b00:   o_q_next = i_q;
            2'b01:   o_q_next = 1'b0;
            2'b10:   o_q_next = 1'b1;
            default: o_q_next = ~i_q;
        endcase
    end

endmodule : jk_next_bit
`default_nettype wire

// File: rtl/jk_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_register_bank
//  Description : WIDTH-bit register operating as a JK bank, an up/down
//                counter or a bidirectional shift register, with parallel
//                load. Optional build macro JKREG_SATURATE_EN makes the
//                counter saturate at its limits instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_register_bank
    import jkreg_pkg::*;
#(
    parameter int                WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             dir,
    input  logic             ser_in,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ser_out
);

    localparam logic [WIDTH-1:0] c_ones = '1;
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] reg_q, reg_d;
    logic             tc_q, tc_d;
    logic             ser_out_q, ser_out_d;
    logic [WIDTH-1:0] w_jk_next;
    logic [WIDTH-1:0] w_inc, w_dec;

    assign w_inc = reg_q + c_one;
    assign w_dec = reg_q - c_one;

    // One independent JK cell per register bit
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bits
            jk_next_bit u_jk_next_bit (
                .i_q      (reg_q[gi]),
                .i_j      (j[gi]),
                .i_k      (k[gi]),
                .o_q_next (w_jk_next[gi])
            );
        end
    endgenerate

    // Next-state selection: load beats enabled operation; tc is a one-edge pulse
    always_comb begin
        reg_d     = reg_q;
        tc_d      = 1'b0;
        ser_out_d = ser_out_q;
        if (load) begin
            reg_d = d;
        end else if (en) begin
            unique case (mode)
                MODE_JK: begin
                    reg_d = w_jk_next;
                end
                MODE_COUNT: begin
                    if (dir == DIR_UP) begin
`ifdef JKREG_SATURATE_EN
                        if (reg_q != c_ones) begin
                            reg_d = w_inc;
                            tc_d  = (w_inc == c_ones);
                        end
`else
                        reg_d = w_inc;
                        tc_d  = (reg_q == c_ones);
`endif
                    end else begin
`ifdef JKREG_SATURATE_EN
                        if (reg_q != c_zero) begin
                            reg_d = w_dec;
                            tc_d  = (w_dec == c_zero);
                        end
`else
                        reg_d = w_dec;
                        tc_d  = (reg_q == c_zero);
`endif
                    end
                end
                MODE_SHIFT: begin
                    if (dir == DIR_LEFT) begin
                        reg_d     = {reg_q[WIDTH-2:0], ser_in};
                        ser_out_d = reg_q[WIDTH-1];
                    end else begin
                        reg_d     = {ser_in, reg_q[WIDTH-1:1]};
                        ser_out_d = reg_q[0];
                    end
                end
                default: begin
                    reg_d = reg_q;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_q     <= RESET_VAL;
            tc_q      <= 1'b0;
            ser_out_q <= 1'b0;
        end else begin
            reg_q     <= reg_d;
            tc_q      <= tc_d;
            ser_out_q <= ser_out_d;
        end
    end

    assign q       = reg_q;
    assign tc      = tc_q;
    assign ser_out = ser_out_q;

endmodule : jk_register_bank
`default_nettype wire

// File: tb/tb_jk_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_register_bank
//  Description : Directed self-checking bench for jk_register_bank (WIDTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_register_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j, k;
    logic         dir;
    logic         ser_in;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         ser_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_register_bank #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .dir     (dir),
        .ser_in  (ser_in),
        .load    (load),
        .d       (d),
        .q       (q),
        .tc      (tc),
        .ser_out (ser_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [W-1:0] eq, input logic etc, input logic eso);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".tc"}, 32'(tc), 32'(etc));
        chk({tag, ".ser_out"}, 32'(ser_out), 32'(eso));
    endtask

    initial begin
        rst = 1'b0; load = 1'b1; d = 4'hA; en = 1'b0; mode = 2'b00;
        j = '0; k = '0; dir = 1'b0; ser_in = 1'b0;

        // reset dominates load
        tick(); tick();
        chk3("reset", 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk3("load_after_reset", 4'hA, 1'b0, 1'b0);

        // JK mode: 1010 with j=1100 k=0110 -> set,toggle,clear,hold = 1100
        load = 1'b0; en = 1'b1; mode = 2'b00; j = 4'b1100; k = 4'b0110;
        tick();
        chk("jk_mix", 32'(q), 32'h0000_000C);
        j = 4'b0011; k = 4'b0011;
        tick();
        chk("jk_toggle", 32'(q), 32'h0000_000F);
        j = 4'b0000; k = 4'b1111;
        tick();
        chk3("jk_clear", 4'h0, 1'b0, 1'b0);

        // count up from E
        load = 1'b1; d = 4'hE;
        tick();
        load = 1'b0; mode = 2'b01; dir = 1'b1;
`ifdef JKREG_SATURATE_EN
        tick(); chk3("up1", 4'hF, 1'b1, 1'b0);
        tick(); chk3("up2", 4'hF, 1'b0, 1'b0);
        tick(); chk3("up3", 4'hF, 1'b0, 1'b0);
`else
        tick(); chk3("up1", 4'hF, 1'b0, 1'b0);
        tick(); chk3("up2", 4'h0, 1'b1, 1'b0);
        tick(); chk3("up3", 4'h1, 1'b0, 1'b0);
`endif

        // count down from 1, then drop enable
        load = 1'b1; d = 4'h1;
        tick();
        load = 1'b0; dir = 1'b0;
`ifdef JKREG_SATURATE_EN
        tick(); chk3("dn1", 4'h0, 1'b1, 1'b0);
        tick(); chk3("dn2", 4'h0, 1'b0, 1'b0);
        en = 1'b0;
        tick(); chk3("dn_hold", 4'h0, 1'b0, 1'b0);
`else
        tick(); chk3("dn1", 4'h0, 1'b0, 1'b0);
        tick(); chk3("dn2", 4'hF, 1'b1, 1'b0);
        en = 1'b0;
        tick(); chk3("dn_hold", 4'hF, 1'b0, 1'b0);
`endif

        // HOLD mode with enable high
        en = 1'b1; mode = 2'b11; load = 1'b1; d = 4'h6;
        tick();
        load = 1'b0;
        tick(); chk3("hold_mode", 4'h6, 1'b0, 1'b0);

        // shift left then right
        load = 1'b1; d = 4'b1001;
        tick();
        load = 1'b0; mode = 2'b10; dir = 1'b1; ser_in = 1'b0;
        tick(); chk3("shl", 4'b0010, 1'b0, 1'b1);
        dir = 1'b0; ser_in = 1'b1;
        tick(); chk3("shr1", 4'b1001, 1'b0, 1'b0);
        ser_in = 1'b0;
        tick(); chk3("shr2", 4'b0100, 1'b0, 1'b1);
        en = 1'b0;
        tick(); chk3("sh_en_off", 4'b0100, 1'b0, 1'b1);

        // load beats an enabled count; ser_out untouched by load
        en = 1'b1; mode = 2'b01; dir = 1'b1; load = 1'b1; d = 4'h5;
        tick(); chk3("load_prio", 4'h5, 1'b0, 1'b1);

        // reset beats load
        rst = 1'b0;
        tick(); chk3("rst_prio", 4'h0, 1'b0, 1'b0);
        rst = 1'b1; load = 1'b0; en = 1'b0;
        tick(); chk3("post_rst", 4'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_jk_register_bank
`default_nettype wire
